hardwired_control: RTL and testbench
====================================

Name: hardwired_control

Overview:
- Moore-style control sequencer that drives every control strobe the bus datapath currently receives from hand-written bench sequences.
- Sits directly upstream of the `bus` datapath. It consumes the instruction register contents and produces the register-select, load, drive, memory and ALU-operation signals for fetch, decode and execute.
- Supported instruction classes: R-type ALU, immediate ALU, mul/div, unary (neg/not), nop and halt.

Parameters:
- RESET_PC_HOLD, 1, number of idle RST cycles after clear deasserts before the first T0 (1..3).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- IR  in  32  instruction register; [31:27] opcode, [26:23] ra, [22:19] rb, [18:15] rc.
- stop  in  1  request to halt at the next instruction boundary.
- run  out  1  high unless in HALT or RST.
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR strobes.
- read, MDRin, MDRout, IRin  out  1 each  memory/MDR/IR strobes.
- Yin, Zlowin, Zhighin, ZLOout, ZHIout  out  1 each  ALU operand and result strobes.
- LOin, HIin  out  1 each  mul/div result loads.
- Gra, Grb, Grc, Rin, Rout, Cout  out  1 each  register field select and drive/load qualifiers, consumed by datapath select/encode logic.
- operation  out  5  ALU function code.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset:
  - clear high forces state RST immediately (asynchronous), including mid-instruction.
  - All outputs are 0 while in RST, run included.
  - After clear falls, the block stays in RST for RESET_PC_HOLD rising edges, then enters T0.
- State timing: states are registered, one clock each. Outputs decode from state and IR only, so they are stable for the whole cycle. The datapath latches at the rising edge that ends the cycle.
- Default: every strobe not listed for a state is 0, and operation is 5'b00000.
- Fetch:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: ZLOout, PCin, read, MDRin.
  - T2: MDRout, IRin.
  - IR is valid from T3 onward.
- Opcodes (5-bit):
  - R-type: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011.
  - Immediate: addi 01100, andi 01101, ori 01110.
  - Other: mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011.
- R-type:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zlowin, operation = opcode.
  - T5: ZLOout, Gra, Rin; then T0.
- Immediate:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zlowin. operation = 00011 for addi, 00101 for andi, 00110 for ori.
  - T5: ZLOout, Gra, Rin; then T0.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zlowin, Zhighin, operation = opcode.
  - T5: ZLOout, LOin.
  - T6: ZHIout, HIin; then T0.
- neg/not:
  - T3: Grb, Rout, Zlowin, operation = opcode (unary, Y unused).
  - T4: ZLOout, Gra, Rin; then T0.
- nop: T3 performs no strobes, then T0.
- halt: T3 goes to HALT. HALT holds (run=0, all strobes 0) until clear.
- Unsupported opcode: illegal=1 during T3 only, no other strobes, then T0.
- stop: sampled on the edge leaving the last execute state. If it is 1, the next state is HALT instead of T0. A stop asserted during fetch takes effect after that instruction completes; the instruction is never aborted.
- Simultaneous clear and stop: clear wins.

Decomposition:
- Shared include `cpu_defs.vh`:
  - opcode constants;
  - state encodings RST, T0–T6, HALT (4-bit);
  - the IR field bit positions.
- One combinational sub-module, `instr_class_decode`:
  - input: opcode;
  - output: one-hot class {rtype, imm, muldiv, unary, nop, halt, bad};
  - output: mapped ALU op for the immediate class.

Test Plan:
- Reset: clear pulse with RESET_PC_HOLD=1 -> all outputs 0 during clear; T0 strobes (PCout, MARin, IncPC, Zlowin) on the 2nd rising edge after clear falls.
- IR=0x30918000 (or R1,R2,R3) -> T3 Grb+Rout+Yin; T4 Grc+Rout+Zlowin with operation=00110; T5 ZLOout+Gra+Rin; T0 next. Integrated with bus: R2=0x12, R3=0x14 -> R1=0x16.
- IR opcode 01101 (andi) -> T4 asserts Cout (not Grc/Rout) and operation=00101.
- IR opcode 01111 (mul) -> T5 LOin+ZLOout, T6 HIin+ZHIout, then T0; total 7 cycles per instruction.
- IR opcode 11111 -> illegal high for exactly the T3 cycle, no Rin/Yin, returns to T0. IR opcode 11011 -> run falls after T3 and stays 0 for 20 cycles until clear.
- stop raised during T1 of an add -> instruction completes through T5, then HALT with run=0. clear asserted in T4 -> outputs 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/hardwired_control_pkg.sv
// -----------------------------------------------------------------------------
// hardwired_control_pkg
//   Shared definitions for the hardwired control sequencer: opcode constants,
//   sequencer state encoding, instruction-register field positions and the
//   one-hot instruction class record produced by instr_class_decode.
// -----------------------------------------------------------------------------
package hardwired_control_pkg;

  // Instruction register field positions
  localparam int IR_OPC_MSB = 31;
  localparam int IR_OPC_LSB = 27;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_MSB  = 22;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_MSB  = 18;
  localparam int IR_RC_LSB  = 15;

  // Opcodes; the R-type, mul/div and unary opcodes double as ALU function codes
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Sequencer states, one clock each
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  // One-hot instruction class
  typedef struct packed {
    logic rtype;
    logic imm;
    logic muldiv;
    logic unary;
    logic nop;
    logic halt;
    logic bad;
  } instr_class_t;

  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[IR_OPC_MSB:IR_OPC_LSB];
  endfunction

endpackage

// File: rtl/hardwired_control_if.sv
// -----------------------------------------------------------------------------
// hardwired_control_if
//   Bundle between the control sequencer and the bus datapath.
//   master : the sequencer (reads IR/stop, drives all strobes)
//   slave  : the datapath side (drives IR/stop, consumes strobes)
// -----------------------------------------------------------------------------
interface hardwired_control_if;
  logic [31:0] IR;
  logic        stop;
  logic        run;
  logic        PCout, PCin, IncPC, MARin;
  logic        read, MDRin, MDRout, IRin;
  logic        Yin, Zlowin, Zhighin, ZLOout, ZHIout;
  logic        LOin, HIin;
  logic        Gra, Grb, Grc, Rin, Rout, Cout;
  logic [4:0]  operation;
  logic        illegal;

  modport master (
    input  IR, stop,
    output run, PCout, PCin, IncPC, MARin, read, MDRin, MDRout, IRin,
           Yin, Zlowin, Zhighin, ZLOout, ZHIout, LOin, HIin,
           Gra, Grb, Grc, Rin, Rout, Cout, operation, illegal
  );

  modport slave (
    output IR, stop,
    input  run, PCout, PCin, IncPC, MARin, read, MDRin, MDRout, IRin,
           Yin, Zlowin, Zhighin, ZLOout, ZHIout, LOin, HIin,
           Gra, Grb, Grc, Rin, Rout, Cout, operation, illegal
  );
endinterface

// File: rtl/hardwired_control_instr_class_decode.sv
// -----------------------------------------------------------------------------
// instr_class_decode
//   Purely combinational opcode classifier.
//   i_opcode : 5-bit opcode from IR
//   o_class  : one-hot {rtype, imm, muldiv, unary, nop, halt, bad}
//   o_imm_op : ALU function code for the immediate class
// -----------------------------------------------------------------------------
module instr_class_decode
  import hardwired_control_pkg::*;
(
  input  logic [4:0]   i_opcode,
  output instr_class_t o_class,
  output logic [4:0]   o_imm_op
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    o_class  = '0;
    o_imm_op = OP_ADD;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: o_class.rtype  = 1'b1;
      OP_ADDI: begin o_class.imm = 1'b1; o_imm_op = OP_ADD; end
      OP_ANDI: begin o_class.imm = 1'b1; o_imm_op = OP_AND; end
      OP_ORI:  begin o_class.imm = 1'b1; o_imm_op = OP_OR;  end
      OP_MUL, OP_DIV:                  o_class.muldiv = 1'b1;
      OP_NEG, OP_NOT:                  o_class.unary  = 1'b1;
      OP_NOP:                          o_class.nop    = 1'b1;
      OP_HALT:                         o_class.halt   = 1'b1;
      default:                         o_class.bad    = 1'b1;
    endcase
  end

endmodule

// File: rtl/hardwired_control.sv
// -----------------------------------------------------------------------------
// hardwired_control
//   Moore control sequencer for the bus datapath: fetch (T0-T2), then a
//   class-dependent execute sequence (T3-T6), with RST and HALT states.
//   clock : rising-edge clock
//   clear : asynchronous active-high reset, forces RST
//   bus   : master side of hardwired_control_if (IR, stop in; strobes out)
//   RESET_PC_HOLD : idle RST edges after clear falls before the first T0 (1..3)
// -----------------------------------------------------------------------------
module hardwired_control
  import hardwired_control_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic                clock,
  input  logic                clear,
  hardwired_control_if.master bus
);

  localparam logic [1:0] HOLD_LAST = 2'(RESET_PC_HOLD);

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_hold;
  logic [4:0]   w_opcode;
  instr_class_t w_class;
  logic [4:0]   w_imm_op;
  state_t       w_boundary;

  assign w_opcode = opcode_of(bus.IR);

  instr_class_decode u_decode (
    .i_opcode (w_opcode),
    .o_class  (w_class),
    .o_imm_op (w_imm_op)
  );

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_RST;
      r_hold  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= w_next;
      if (r_state == ST_RST && r_hold != HOLD_LAST)
        r_hold <= r_hold + 2'd1;
    end
  end

  // Where the last execute state goes: stop is only honoured at the boundary
  assign w_boundary = bus.stop ? ST_HALT : ST_T0;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:  w_next = (r_hold == HOLD_LAST) ? ST_T0 : ST_RST;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = ST_T2;
      ST_T2:   w_next = ST_T3;
      ST_T3: begin
        if (w_class.halt)                    w_next = ST_HALT;
        else if (w_class.nop || w_class.bad) w_next = w_boundary;
        else                                 w_next = ST_T4;
      end
      ST_T4:   w_next = w_class.unary  ? w_boundary : ST_T5;
      ST_T5:   w_next = w_class.muldiv ? ST_T6 : w_boundary;
      ST_T6:   w_next = w_boundary;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase
  end

  // Output decode (state and IR only)
  always_comb begin
    bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
    bus.read = 1'b0; bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0;
    bus.Yin = 1'b0; bus.Zlowin = 1'b0; bus.Zhighin = 1'b0;
    bus.ZLOout = 1'b0; bus.ZHIout = 1'b0; bus.LOin = 1'b0; bus.HIin = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.Rin = 1'b0; bus.Rout = 1'b0; bus.Cout = 1'b0;
    bus.operation = 5'b00000;
    bus.illegal   = 1'b0;
    bus.run       = (r_state != ST_RST) && (r_state != ST_HALT);

    case (r_state)
      ST_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1; end
      ST_T1: begin bus.ZLOout = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1; end
      ST_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      ST_T3: begin
        if (w_class.rtype || w_class.imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (w_class.muldiv) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (w_class.unary) begin
          // Unary ops read their single operand straight onto the ALU; Y unused
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1;
          bus.operation = w_opcode;
        end else if (w_class.bad) begin
          bus.illegal = 1'b1;
        end
      end
      ST_T4: begin
        if (w_class.rtype) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1;
          bus.operation = w_opcode;
        end else if (w_class.imm) begin
          bus.Cout = 1'b1; bus.Zlowin = 1'b1;
          bus.operation = w_imm_op;
        end else if (w_class.muldiv) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.Zhighin = 1'b1;
          bus.operation = w_opcode;
        end else if (w_class.unary) begin
          bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      ST_T5: begin
        if (w_class.muldiv) begin
          bus.ZLOout = 1'b1; bus.LOin = 1'b1;
        end else begin
          bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      ST_T6: begin bus.ZHIout = 1'b1; bus.HIin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hardwired_control.sv
// -----------------------------------------------------------------------------
// tb_hardwired_control
//   Directed bench for hardwired_control: steps the sequencer one cycle at a
//   time and compares every strobe, run, illegal and operation against
//   hand-written expected vectors.
// -----------------------------------------------------------------------------
module tb_hardwired_control;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_errors;

  hardwired_control_if bus_if ();

  hardwired_control #(.RESET_PC_HOLD(1)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe vector bit masks
  localparam logic [22:0] M_PCOUT  = 23'd1 << 22;
  localparam logic [22:0] M_PCIN   = 23'd1 << 21;
  localparam logic [22:0] M_INCPC  = 23'd1 << 20;
  localparam logic [22:0] M_MARIN  = 23'd1 << 19;
  localparam logic [22:0] M_READ   = 23'd1 << 18;
  localparam logic [22:0] M_MDRIN  = 23'd1 << 17;
  localparam logic [22:0] M_MDROUT = 23'd1 << 16;
  localparam logic [22:0] M_IRIN   = 23'd1 << 15;
  localparam logic [22:0] M_YIN    = 23'd1 << 14;
  localparam logic [22:0] M_ZLIN   = 23'd1 << 13;
  localparam logic [22:0] M_ZHIN   = 23'd1 << 12;
  localparam logic [22:0] M_ZLOOUT = 23'd1 << 11;
  localparam logic [22:0] M_ZHIOUT = 23'd1 << 10;
  localparam logic [22:0] M_LOIN   = 23'd1 << 9;
  localparam logic [22:0] M_HIIN   = 23'd1 << 8;
  localparam logic [22:0] M_GRA    = 23'd1 << 7;
  localparam logic [22:0] M_GRB    = 23'd1 << 6;
  localparam logic [22:0] M_GRC    = 23'd1 << 5;
  localparam logic [22:0] M_RIN    = 23'd1 << 4;
  localparam logic [22:0] M_ROUT   = 23'd1 << 3;
  localparam logic [22:0] M_COUT   = 23'd1 << 2;
  localparam logic [22:0] M_ILL    = 23'd1 << 1;
  localparam logic [22:0] M_RUN    = 23'd1 << 0;

  localparam logic [22:0] E_T0    = M_PCOUT | M_MARIN | M_INCPC | M_ZLIN | M_RUN;
  localparam logic [22:0] E_T1    = M_ZLOOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [22:0] E_T2    = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [22:0] E_RD_B  = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [22:0] E_WB_A  = M_ZLOOUT | M_GRA | M_RIN | M_RUN;

  function automatic logic [22:0] strobes();
    return {bus_if.PCout, bus_if.PCin, bus_if.IncPC, bus_if.MARin,
            bus_if.read, bus_if.MDRin, bus_if.MDRout, bus_if.IRin,
            bus_if.Yin, bus_if.Zlowin, bus_if.Zhighin, bus_if.ZLOout, bus_if.ZHIout,
            bus_if.LOin, bus_if.HIin, bus_if.Gra, bus_if.Grb, bus_if.Grc,
            bus_if.Rin, bus_if.Rout, bus_if.Cout, bus_if.illegal, bus_if.run};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare the current cycle, then advance to the next falling edge
  task automatic check_cycle(input string tag, input logic [22:0] exp_s,
                             input logic [4:0] exp_op);
    check(tag, {9'd0, strobes()}, {9'd0, exp_s});
    check({tag, ".op"}, {27'd0, bus_if.operation}, {27'd0, exp_op});
    @(negedge clock);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    #1;
    check("clear_async", {9'd0, strobes()}, 32'd0);
    @(negedge clock);
    check("clear_held", {9'd0, strobes()}, 32'd0);
    clear = 1'b0;
    @(negedge clock);
    check("rst_hold", {9'd0, strobes()}, 32'd0);
    @(negedge clock);
  endtask

  task automatic fetch(input string tag);
    check_cycle({tag, ".T0"}, E_T0, 5'b00000);
    check_cycle({tag, ".T1"}, E_T1, 5'b00000);
    check_cycle({tag, ".T2"}, E_T2, 5'b00000);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    clear       = 1'b1;
    bus_if.stop = 1'b0;
    bus_if.IR   = 32'h3091_8000;
    @(negedge clock);
    do_reset();

    // or R1,R2,R3
    fetch("or");
    check_cycle("or.T3", E_RD_B, 5'b00000);
    check_cycle("or.T4", M_GRC | M_ROUT | M_ZLIN | M_RUN, 5'b00110);
    check_cycle("or.T5", E_WB_A, 5'b00000);

    // andi
    bus_if.IR = mk_ir(5'b01101, 4'd4, 4'd5, 4'd0);
    fetch("andi");
    check_cycle("andi.T3", E_RD_B, 5'b00000);
    check_cycle("andi.T4", M_COUT | M_ZLIN | M_RUN, 5'b00101);
    check_cycle("andi.T5", E_WB_A, 5'b00000);

    // addi and ori immediate op mapping
    bus_if.IR = mk_ir(5'b01100, 4'd1, 4'd1, 4'd0);
    fetch("addi");
    check_cycle("addi.T3", E_RD_B, 5'b00000);
    check_cycle("addi.T4", M_COUT | M_ZLIN | M_RUN, 5'b00011);
    check_cycle("addi.T5", E_WB_A, 5'b00000);
    bus_if.IR = mk_ir(5'b01110, 4'd1, 4'd1, 4'd0);
    fetch("ori");
    check_cycle("ori.T3", E_RD_B, 5'b00000);
    check_cycle("ori.T4", M_COUT | M_ZLIN | M_RUN, 5'b00110);
    check_cycle("ori.T5", E_WB_A, 5'b00000);

    // shl: top of the R-type range
    bus_if.IR = mk_ir(5'b01011, 4'd2, 4'd3, 4'd4);
    fetch("shl");
    check_cycle("shl.T3", E_RD_B, 5'b00000);
    check_cycle("shl.T4", M_GRC | M_ROUT | M_ZLIN | M_RUN, 5'b01011);
    check_cycle("shl.T5", E_WB_A, 5'b00000);

    // mul: seven cycles, next fetch immediately follows T6
    bus_if.IR = mk_ir(5'b01111, 4'd6, 4'd7, 4'd0);
    fetch("mul");
    check_cycle("mul.T3", M_GRA | M_ROUT | M_YIN | M_RUN, 5'b00000);
    check_cycle("mul.T4", M_GRB | M_ROUT | M_ZLIN | M_ZHIN | M_RUN, 5'b01111);
    check_cycle("mul.T5", M_ZLOOUT | M_LOIN | M_RUN, 5'b00000);
    check_cycle("mul.T6", M_ZHIOUT | M_HIIN | M_RUN, 5'b00000);

    // div
    bus_if.IR = mk_ir(5'b10000, 4'd6, 4'd7, 4'd0);
    fetch("div");
    check_cycle("div.T3", M_GRA | M_ROUT | M_YIN | M_RUN, 5'b00000);
    check_cycle("div.T4", M_GRB | M_ROUT | M_ZLIN | M_ZHIN | M_RUN, 5'b10000);
    check_cycle("div.T5", M_ZLOOUT | M_LOIN | M_RUN, 5'b00000);
    check_cycle("div.T6", M_ZHIOUT | M_HIIN | M_RUN, 5'b00000);

    // neg (unary)
    bus_if.IR = mk_ir(5'b10001, 4'd8, 4'd9, 4'd0);
    fetch("neg");
    check_cycle("neg.T3", M_GRB | M_ROUT | M_ZLIN | M_RUN, 5'b10001);
    check_cycle("neg.T4", E_WB_A, 5'b00000);

    // not (unary)
    bus_if.IR = mk_ir(5'b10010, 4'd8, 4'd9, 4'd0);
    fetch("not");
    check_cycle("not.T3", M_GRB | M_ROUT | M_ZLIN | M_RUN, 5'b10010);
    check_cycle("not.T4", E_WB_A, 5'b00000);

    // nop
    bus_if.IR = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
    fetch("nop");
    check_cycle("nop.T3", M_RUN, 5'b00000);

    // Unsupported opcodes: 11111 and 00000
    bus_if.IR = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
    fetch("bad1f");
    check_cycle("bad1f.T3", M_ILL | M_RUN, 5'b00000);
    bus_if.IR = mk_ir(5'b00000, 4'd1, 4'd2, 4'd3);
    fetch("bad00");
    check_cycle("bad00.T3", M_ILL | M_RUN, 5'b00000);

    // stop raised in T1 of an add: completes through T5, then HALT
    bus_if.IR = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
    check_cycle("stop.T0", E_T0, 5'b00000);
    bus_if.stop = 1'b1;
    check_cycle("stop.T1", E_T1, 5'b00000);
    check_cycle("stop.T2", E_T2, 5'b00000);
    check_cycle("stop.T3", E_RD_B, 5'b00000);
    check_cycle("stop.T4", M_GRC | M_ROUT | M_ZLIN | M_RUN, 5'b00011);
    check_cycle("stop.T5", E_WB_A, 5'b00000);
    for (int i = 0; i < 3; i++) check_cycle("stop.halt", 23'd0, 5'b00000);
    bus_if.stop = 1'b0;
    check_cycle("stop.halt_held", 23'd0, 5'b00000);

    // Recover from HALT with clear, then execute halt
    do_reset();
    bus_if.IR = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
    fetch("halt");
    check_cycle("halt.T3", M_RUN, 5'b00000);
    for (int i = 0; i < 20; i++) check_cycle("halt.idle", 23'd0, 5'b00000);

    // clear asserted in T4 clears outputs before the next edge
    do_reset();
    bus_if.IR = mk_ir(5'b00100, 4'd1, 4'd2, 4'd3);
    fetch("sub");
    check_cycle("sub.T3", E_RD_B, 5'b00000);
    check("sub.T4", {9'd0, strobes()}, {9'd0, M_GRC | M_ROUT | M_ZLIN | M_RUN});
    check("sub.T4.op", {27'd0, bus_if.operation}, {27'd0, 5'b00100});
    do_reset();
    bus_if.IR = 32'h3091_8000;
    fetch("post");
    check_cycle("post.T3", E_RD_B, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
